zap_mem_inv_ctrl: RTL and testbench
===================================

Name: zap_mem_inv_ctrl

Overview:
Access controller for a single valid-tracked RAM with a 1-cycle bulk invalidate.
- Shares the RAM read port between two lookup clients with round-robin arbitration.
- Owns the single write port.
- Sequences bulk invalidates: drains in-flight reads, then pulses invalidate.
- Tags each read with its requester ID so responses return RD_LAT cycles after grant. Sits between the cache/TLB lookup logic and the RAM.

Parameters:
DEPTH, 32, RAM entries; AW = $clog2(DEPTH).
WIDTH, 32, data width excluding valid bit.
RD_LAT, 3, cycles from read address presented to RAM data/valid output (>=1).

Ports:
i_clk  in  1  clock.
i_reset_n  in  1  asynchronous active-low reset.
i_rd_req0, i_rd_req1  in  1 each  read request, held until granted.
i_rd_addr0, i_rd_addr1  in  AW each  read addresses.
o_rd_gnt0, o_rd_gnt1  out  1 each  combinational grant, same cycle as acceptance.
i_wr_req  in  1  write request, held until acked.
i_wr_addr  in  AW  write address.
i_wr_data  in  WIDTH  write data.
o_wr_ack  out  1  combinational write acceptance.
i_inv_req  in  1  invalidate request, held until acked.
o_inv_ack  out  1  one-cycle pulse, coincident with o_mem_inv.
o_mem_clken  out  1  RAM clock enable.
o_mem_wen  out  1  RAM write enable.
o_mem_waddr  out  AW  RAM write address.
o_mem_wdata  out  WIDTH  RAM write data.
o_mem_raddr  out  AW  RAM read address.
o_mem_inv  out  1  RAM bulk invalidate.
i_mem_rdata  in  WIDTH  RAM read data, RD_LAT after address.
i_mem_rdav  in  1  RAM read valid bit, RD_LAT after address.
o_rsp_valid  out  1  response strobe.
o_rsp_id  out  1  requester of the response.
o_rsp_data  out  WIDTH  equals i_mem_rdata.
o_rsp_hit  out  1  equals i_mem_rdav when o_rsp_valid, else 0.
o_busy  out  1  high in DRAIN/INV or when any tag stage is valid.

Behaviour:
- Reset (async, i_reset_n=0):
  - State RUN.
  - Tag pipeline cleared.
  - RR pointer = 1 (client 0 wins first contention).
  - Registered/state-derived outputs 0: o_rsp_valid, o_rsp_id, o_rsp_hit, o_busy, o_inv_ack, o_mem_inv.
  - Grant/ack outputs 0 while reset asserted.
  - o_mem_clken = 1 whenever i_reset_n=1.
  - Reset mid-drain or mid-invalidate drops all in-flight responses; no ack is issued.
- States:
  - RUN -> DRAIN when i_inv_req=1.
  - DRAIN -> INV when the tag pipeline is empty, evaluated in DRAIN.
  - INV -> RUN unconditionally after 1 cycle.
  - i_inv_req is ignored in INV. If still high in the following RUN cycle, it is a new request.
- Reads (RUN only, and only when i_inv_req=0 that cycle):
  - Single requester: granted.
  - Both requesting: grant the client != RR pointer; RR pointer <= granted ID.
  - o_mem_raddr = granted address (combinational); otherwise holds the last granted address.
  - Grant pushes {valid=1, id} into tag stage 0. Stage RD_LAT-1 drives o_rsp_valid/o_rsp_id.
  - Response appears exactly RD_LAT cycles after the grant cycle. Full throughput: 1 grant per cycle.
- Writes (RUN only, i_inv_req=0):
  - o_wr_ack = i_wr_req.
  - o_mem_wen = o_wr_ack; o_mem_waddr/o_mem_wdata pass through.
  - A write may co-issue with a read in the same cycle.
  - Same-address read/write coherence is provided by the RAM; the controller passes the RAM result unmodified.
- Blocking rules:
  - In the cycle i_inv_req rises in RUN, and throughout DRAIN and INV, no read grants and no write acks.
  - The tag pipeline keeps shifting, so in-flight responses are delivered.
- INV cycle: o_mem_inv=1, o_inv_ack=1, for exactly one cycle.
- Minimum invalidate latency with an empty pipeline: req at cycle 0, DRAIN at cycle 1, INV/ack at cycle 2.
- o_rsp_hit is masked to 0 when o_rsp_valid=0.

Test Plan:
1. Reset release, single read: i_rd_req0=1, addr 5 at cycle 0 -> o_rd_gnt0=1 at cycle 0; o_rsp_valid=1, id=0 at cycle 3 (RD_LAT=3); hit=0 on empty RAM.
2. Write then read: write addr 7 = 0xDEADBEEF, then read addr 7 from client 1 -> response id=1, data 0xDEADBEEF, hit=1, 3 cycles after grant.
3. Contention: both clients request continuously for 4 cycles -> grants 0,1,0,1; responses return in the same order with matching IDs.
4. Invalidate with 3 reads in flight: i_inv_req at cycle 0 -> no grants from cycle 0; all 3 responses delivered; o_mem_inv/o_inv_ack exactly once, after the last response; a subsequent read of addr 7 gives hit=0.
5. Invalidate when idle: req at cycle 0 -> ack at cycle 2; a simultaneous write at cycle 0 is not acked, and is acked at cycle 3.
6. Async reset mid-DRAIN: i_reset_n low between clock edges -> o_rsp_valid, o_busy and o_inv_ack drop immediately; no ack after release; client 0 wins the first contention.

Source files
------------

// File: rtl/zap_mem_inv_ctrl.sv
// Read/write access controller for a valid-tracked RAM with drained bulk invalidate.
// Two lookup clients share the read port round-robin; responses carry the requester ID.
module zap_mem_inv_ctrl #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 32,
  parameter int RD_LAT = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_rd_req0,
  input  logic             i_rd_req1,
  input  logic [AW-1:0]    i_rd_addr0,
  input  logic [AW-1:0]    i_rd_addr1,
  output logic             o_rd_gnt0,
  output logic             o_rd_gnt1,
  input  logic             i_wr_req,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ack,
  input  logic             i_inv_req,
  output logic             o_inv_ack,
  output logic             o_mem_clken,
  output logic             o_mem_wen,
  output logic [AW-1:0]    o_mem_waddr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [AW-1:0]    o_mem_raddr,
  output logic             o_mem_inv,
  input  logic [WIDTH-1:0] i_mem_rdata,
  input  logic             i_mem_rdav,
  output logic             o_rsp_valid,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_hit,
  output logic             o_busy
);
  localparam int STAGES = RD_LAT - 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_INV} state_t;

  state_t         state;
  logic           rr_ptr;
  logic           inv_q;
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] id_pipe;
  logic [AW-1:0]  raddr_q;
  logic           open;
  logic           gnt_any;
  logic           gnt_id;

  // The cycle an invalidate request appears already blocks new traffic.
  assign open = i_reset_n && (state == S_RUN) && !i_inv_req;

  // rr_ptr holds the last contention winner; the other client wins next time.
  assign o_rd_gnt0 = open && i_rd_req0 && (!i_rd_req1 ||  rr_ptr);
  assign o_rd_gnt1 = open && i_rd_req1 && (!i_rd_req0 || !rr_ptr);
  assign gnt_any   = o_rd_gnt0 || o_rd_gnt1;
  assign gnt_id    = o_rd_gnt1;

  assign o_mem_raddr = o_rd_gnt0 ? i_rd_addr0 : (o_rd_gnt1 ? i_rd_addr1 : raddr_q);

  assign o_wr_ack    = open && i_wr_req;
  assign o_mem_wen   = o_wr_ack;
  assign o_mem_waddr = i_wr_addr;
  assign o_mem_wdata = i_wr_data;
  assign o_mem_clken = i_reset_n;

  assign o_inv_ack   = inv_q;
  assign o_mem_inv   = inv_q;
  assign o_busy      = (state != S_RUN) || (|vld_pipe);

  assign o_rsp_valid = vld_pipe[STAGES];
  assign o_rsp_id    = id_pipe[STAGES];
  assign o_rsp_data  = i_mem_rdata;
  assign o_rsp_hit   = vld_pipe[STAGES] && i_mem_rdav;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_RUN;
      inv_q    <= 1'b0;
      rr_ptr   <= 1'b1;
      vld_pipe <= '0;
      id_pipe  <= '0;
      raddr_q  <= '0;
    end else begin
      vld_pipe[0] <= gnt_any;
      id_pipe[0]  <= gnt_id;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
      if (gnt_any) raddr_q <= o_mem_raddr;
      if (o_rd_gnt0 && i_rd_req1) rr_ptr <= 1'b0;
      if (o_rd_gnt1 && i_rd_req0) rr_ptr <= 1'b1;
      inv_q <= 1'b0;
      case (state)
        S_RUN:   if (i_inv_req) state <= S_DRAIN;
        S_DRAIN: if (vld_pipe == '0) begin
                   state <= S_INV;
                   inv_q <= 1'b1;
                 end
        S_INV:   state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_zap_mem_inv_ctrl.sv
// Table-driven bench for zap_mem_inv_ctrl with a behavioural RAM and a response scoreboard.
module tb_zap_mem_inv_ctrl;
  localparam int DEPTH = 32, WIDTH = 32, RD_LAT = 3, AW = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic r0 = 0, r1 = 0, w = 0, inv = 0;
  logic [AW-1:0] a0 = '0, a1 = '0, wa = '0;
  logic [WIDTH-1:0] wd = '0;
  logic g0, g1, wk, ik, clken, mwen, minv, rdav, rv, rid, rhit, busy;
  logic [AW-1:0] mwaddr, mraddr;
  logic [WIDTH-1:0] mwdata, rdata, rsp_data;

  always #5 clk = ~clk;

  zap_mem_inv_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_rd_req0(r0), .i_rd_req1(r1), .i_rd_addr0(a0), .i_rd_addr1(a1),
    .o_rd_gnt0(g0), .o_rd_gnt1(g1),
    .i_wr_req(w), .i_wr_addr(wa), .i_wr_data(wd), .o_wr_ack(wk),
    .i_inv_req(inv), .o_inv_ack(ik),
    .o_mem_clken(clken), .o_mem_wen(mwen), .o_mem_waddr(mwaddr), .o_mem_wdata(mwdata),
    .o_mem_raddr(mraddr), .o_mem_inv(minv),
    .i_mem_rdata(rdata), .i_mem_rdav(rdav),
    .o_rsp_valid(rv), .o_rsp_id(rid), .o_rsp_data(rsp_data), .o_rsp_hit(rhit),
    .o_busy(busy)
  );

  // Behavioural RAM: registered read with RD_LAT latency, bulk-clear of valid bits.
  logic [WIDTH-1:0] ram_d [DEPTH];
  logic [DEPTH-1:0] ram_v;
  logic [WIDTH:0]   rp [RD_LAT];
  initial begin
    ram_v = '0;
    for (int i = 0; i < DEPTH; i++) ram_d[i] = 32'h1000 + i;
    for (int i = 0; i < RD_LAT; i++) rp[i] = '0;
  end
  always @(posedge clk) begin
    if (mwen) begin
      ram_d[mwaddr] <= mwdata;
      ram_v[mwaddr] <= 1'b1;
    end
    if (minv) ram_v <= '0;
    rp[0] <= {ram_v[mraddr], ram_d[mraddr]};
    for (int k = 1; k < RD_LAT; k++) rp[k] <= rp[k-1];
  end
  assign rdav  = rp[RD_LAT-1][WIDTH];
  assign rdata = rp[RD_LAT-1][WIDTH-1:0];

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each grant queues the response due RD_LAT cycles later.
  typedef struct { int due; logic id; logic [WIDTH-1:0] data; logic hit; } exp_t;
  exp_t q[$];
  exp_t e, n;
  int cyc = 0;
  logic [AW-1:0] ga;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_rsp_valid", 64'(rv), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk($sformatf("rsp_valid@%0d", cyc), 64'(rv), 64'd1);
        chk($sformatf("rsp_id@%0d", cyc), 64'(rid), 64'(e.id));
        chk($sformatf("rsp_data@%0d", cyc), 64'(rsp_data), 64'(e.data));
        chk($sformatf("rsp_hit@%0d", cyc), 64'(rhit), 64'(e.hit));
      end else begin
        chk($sformatf("rsp_idle@%0d", cyc), 64'(rv), 64'd0);
        chk($sformatf("rsp_hit_mask@%0d", cyc), 64'(rhit), 64'd0);
      end
      if (g0 || g1) begin
        ga = g0 ? a0 : a1;
        n.due = cyc + RD_LAT; n.id = g1; n.data = ram_d[ga]; n.hit = ram_v[ga];
        q.push_back(n);
      end
    end
    cyc++;
  end

  typedef struct {
    logic r0; logic [AW-1:0] a0; logic r1; logic [AW-1:0] a1;
    logic w; logic [AW-1:0] wa; logic [WIDTH-1:0] wd; logic inv;
    logic g0, g1, wk, ik;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic xr0, input int xa0, input logic xr1, input int xa1,
                              input logic xw, input int xwa, input logic [WIDTH-1:0] xwd,
                              input logic xinv, input logic eg0, input logic eg1,
                              input logic ewk, input logic eik);
    vec_t v;
    v.r0 = xr0; v.a0 = AW'(xa0); v.r1 = xr1; v.a1 = AW'(xa1);
    v.w = xw; v.wa = AW'(xwa); v.wd = xwd; v.inv = xinv;
    v.g0 = eg0; v.g1 = eg1; v.wk = ewk; v.ik = eik;
    return v;
  endfunction

  task automatic idle(input int n_rows);
    for (int i = 0; i < n_rows; i++) tbl.push_back(mk(0,0,0,0, 0,0,0, 0, 0,0,0,0));
  endtask

  initial begin
    // Single read, then write/read-back from client 1.
    tbl.push_back(mk(1,5,0,0, 0,0,0, 0, 1,0,0,0));
    idle(3);
    tbl.push_back(mk(0,0,0,0, 1,7,32'hDEADBEEF, 0, 0,0,1,0));
    tbl.push_back(mk(0,0,1,7, 0,0,0, 0, 0,1,0,0));
    idle(3);
    // Continuous contention alternates starting with client 0; write co-issues.
    tbl.push_back(mk(1,1,1,2, 1,9,32'h0000_0099, 0, 1,0,1,0));
    tbl.push_back(mk(1,1,1,2, 0,0,0, 0, 0,1,0,0));
    tbl.push_back(mk(1,9,1,2, 0,0,0, 0, 1,0,0,0));
    tbl.push_back(mk(1,1,1,9, 0,0,0, 0, 0,1,0,0));
    idle(3);
    // Invalidate behind three in-flight reads; blocked traffic, then addr 7 misses.
    tbl.push_back(mk(1,10,0,0, 0,0,0, 0, 1,0,0,0));
    tbl.push_back(mk(0,0,1,11, 0,0,0, 0, 0,1,0,0));
    tbl.push_back(mk(1,7,0,0, 0,0,0, 0, 1,0,0,0));
    tbl.push_back(mk(1,7,1,7, 1,4,32'h44, 1, 0,0,0,0));
    tbl.push_back(mk(1,7,1,7, 1,4,32'h44, 1, 0,0,0,0));
    tbl.push_back(mk(1,7,1,7, 1,4,32'h44, 1, 0,0,0,0));
    tbl.push_back(mk(1,7,1,7, 1,4,32'h44, 1, 0,0,0,0));
    tbl.push_back(mk(1,7,1,7, 1,4,32'h44, 1, 0,0,0,1));
    tbl.push_back(mk(1,7,0,0, 0,0,0, 0, 1,0,0,0));
    idle(3);
    // Idle invalidate: ack two cycles after request, held write waits.
    tbl.push_back(mk(0,0,0,0, 1,3,32'h33, 1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,3,32'h33, 1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,3,32'h33, 1, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,3,32'h33, 0, 0,0,1,0));
    tbl.push_back(mk(0,0,0,3, 0,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,3, 0,0,0, 0, 0,1,0,0));
    idle(4);

    // Reset state with requests pending.
    r0 = 1; w = 1; inv = 1;
    #3;
    chk("rst_gnt0", 64'(g0), 64'd0);
    chk("rst_wr_ack", 64'(wk), 64'd0);
    chk("rst_clken", 64'(clken), 64'd0);
    chk("rst_inv_ack", 64'(ik), 64'd0);
    chk("rst_mem_inv", 64'(minv), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    r0 = 0; w = 0; inv = 0; rst_n = 1;
    #1 chk("clken_run", 64'(clken), 64'd1);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      r0 = tbl[i].r0; a0 = tbl[i].a0; r1 = tbl[i].r1; a1 = tbl[i].a1;
      w = tbl[i].w; wa = tbl[i].wa; wd = tbl[i].wd; inv = tbl[i].inv;
      @(negedge clk);
      chk($sformatf("gnt0[%0d]", i), 64'(g0), 64'(tbl[i].g0));
      chk($sformatf("gnt1[%0d]", i), 64'(g1), 64'(tbl[i].g1));
      chk($sformatf("wr_ack[%0d]", i), 64'(wk), 64'(tbl[i].wk));
      chk($sformatf("mem_wen[%0d]", i), 64'(mwen), 64'(tbl[i].wk));
      chk($sformatf("inv_ack[%0d]", i), 64'(ik), 64'(tbl[i].ik));
      chk($sformatf("mem_inv[%0d]", i), 64'(minv), 64'(tbl[i].ik));
      if (tbl[i].g0 || tbl[i].g1)
        chk($sformatf("raddr[%0d]", i), 64'(mraddr), 64'(tbl[i].g0 ? tbl[i].a0 : tbl[i].a1));
    end

    // Async reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 r0 = 1; r1 = 1; a0 = 1; a1 = 2;
      @(negedge clk);
      chk($sformatf("pre_rst_gnt0[%0d]", i), 64'(g0), 64'(i != 1));
      chk($sformatf("pre_rst_gnt1[%0d]", i), 64'(g1), 64'(i == 1));
    end
    @(posedge clk); #1 r0 = 0; r1 = 0; inv = 1;
    @(posedge clk); #1;
    chk("drain_busy", 64'(busy), 64'd1);
    #1 rst_n = 0; inv = 0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rv), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_inv_ack", 64'(ik), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_inv_ack[%0d]", i), 64'(ik), 64'd0);
    end
    @(posedge clk); #1 r0 = 1; r1 = 1; a0 = 6; a1 = 8;
    @(negedge clk);
    chk("post_rst_rr_gnt0", 64'(g0), 64'd1);
    chk("post_rst_rr_gnt1", 64'(g1), 64'd0);
    @(posedge clk); #1 r0 = 0; r1 = 0;
    repeat (RD_LAT + 2) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
